// File: rtl/vga_console.sv
// Console front end for the 80x30 VGA text buffer: turns a character byte stream into
// single-byte bus writes, tracks the cursor and handles CR, LF, BS, FF and screen clears.
`timescale 1ns/1ps
module vga_console #(
  parameter int          COLS           = 80,
  parameter int          ROWS           = 30,
  parameter logic [7:0]  BLANK          = 8'h20,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic        Hclock,
  input  logic        Hreset,
  input  logic [7:0]  ch_data,
  input  logic        ch_valid,
  output logic        ch_ready,
  output logic        Hselect,
  output logic        Hwrite,
  output logic        Hsize,
  output logic        ready,
  output logic [11:0] Haddress,
  output logic [31:0] Hwritedata,
  input  logic        Hready,
  input  logic        Hresponse,
  output logic [6:0]  cursor_x,
  output logic [4:0]  cursor_y,
  output logic        busy,
  output logic        err
);

  localparam logic [11:0] COLS_W   = 12'(COLS);
  localparam logic [11:0] TOTAL_W  = 12'(COLS * ROWS);
  localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
  localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE      = 2'd1,
    CLEAR_LINE = 2'd2,
    CLEAR_ALL  = 2'd3
  } state_t;

  state_t      state, state_n;
  logic [11:0] ptr, ptr_n;
  logic [11:0] rem, rem_n;
  logic [6:0]  col, col_n;
  logic [4:0]  row, row_n;
  logic [7:0]  wbyte, wbyte_n;
  logic        wrap_pending, wrap_n;
  logic        hsel, hsel_n;
  logic [11:0] addr, addr_n;
  logic [7:0]  wdata, wdata_n;
  logic        ch_ready_q, ch_ready_n;
  logic        busy_q, busy_n;
  logic        err_q;
  logic        accept;
  logic        printable;
  logic [4:0]  row_inc;

  function automatic logic [11:0] cell_addr(input logic [4:0] r, input logic [6:0] c);
    return ({7'd0, r} * COLS_W) + {5'd0, c};
  endfunction

  assign accept    = ch_valid && ch_ready_q;
  assign printable = (ch_data >= 8'h20) && (ch_data <= 8'h7E);
  assign row_inc   = (row == LAST_ROW) ? 5'd0 : row + 5'd1;

  // Next-state decode; ptr/rem describe writes still to be issued by the current state.
  always_comb begin
    state_n    = state;
    ptr_n      = ptr;
    rem_n      = rem;
    col_n      = col;
    row_n      = row;
    wbyte_n    = wbyte;
    wrap_n     = wrap_pending;
    hsel_n     = 1'b0;
    addr_n     = addr;
    wdata_n    = wdata;
    ch_ready_n = 1'b0;
    busy_n     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (printable) begin
            state_n = WRITE;
            ptr_n   = cell_addr(row, col);
            rem_n   = 12'd1;
            wbyte_n = ch_data;
            if (col == LAST_COL) begin
              col_n  = 7'd0;
              row_n  = row_inc;
              wrap_n = 1'b1;
            end else begin
              col_n  = col + 7'd1;
              wrap_n = 1'b0;
            end
          end else begin
            case (ch_data)
              8'h0A: begin
                col_n   = 7'd0;
                row_n   = row_inc;
                state_n = CLEAR_LINE;
                ptr_n   = cell_addr(row_inc, 7'd0);
                rem_n   = COLS_W;
                wbyte_n = BLANK;
              end
              8'h0D: col_n = 7'd0;
              8'h08: begin
                if (col != 7'd0) begin
                  col_n   = col - 7'd1;
                  state_n = WRITE;
                  ptr_n   = cell_addr(row, col - 7'd1);
                  rem_n   = 12'd1;
                  wbyte_n = BLANK;
                  wrap_n  = 1'b0;
                end else begin
                  state_n = IDLE;
                end
              end
              8'h0C: begin
                state_n = CLEAR_ALL;
                ptr_n   = 12'd0;
                rem_n   = TOTAL_W;
                wbyte_n = BLANK;
              end
              default: state_n = IDLE;
            endcase
          end
        end else begin
          state_n = IDLE;
        end
      end
      WRITE: begin
        if (rem == 12'd0) begin
          if (wrap_pending) begin
            state_n = CLEAR_LINE;
            ptr_n   = cell_addr(row, 7'd0);
            rem_n   = COLS_W;
            wbyte_n = BLANK;
            wrap_n  = 1'b0;
          end else begin
            state_n = IDLE;
          end
        end else begin
          state_n = WRITE;
        end
      end
      CLEAR_LINE: begin
        if (rem == 12'd0) begin
          state_n = IDLE;
        end else begin
          state_n = CLEAR_LINE;
        end
      end
      CLEAR_ALL: begin
        if (rem == 12'd0) begin
          state_n = IDLE;
          col_n   = 7'd0;
          row_n   = 5'd0;
        end else begin
          state_n = CLEAR_ALL;
        end
      end
      default: state_n = IDLE;
    endcase

    // A strobe goes out only when the slave was ready at this edge.
    if ((state_n != IDLE) && (rem_n != 12'd0) && Hready) begin
      hsel_n  = 1'b1;
      addr_n  = ptr_n;
      wdata_n = wbyte_n;
      ptr_n   = ptr_n + 12'd1;
      rem_n   = rem_n - 12'd1;
    end else begin
      hsel_n  = 1'b0;
    end
    ch_ready_n = (state_n == IDLE) && Hready;
    busy_n     = (state_n != IDLE);
  end

  // State, cursor and registered bus outputs.
  always_ff @(posedge Hclock or negedge Hreset) begin
    if (!Hreset) begin
      state        <= CLEAR_ON_RESET ? CLEAR_ALL : IDLE;
      rem          <= CLEAR_ON_RESET ? TOTAL_W : 12'd0;
      ptr          <= 12'd0;
      col          <= 7'd0;
      row          <= 5'd0;
      wbyte        <= BLANK;
      wrap_pending <= 1'b0;
      hsel         <= 1'b0;
      addr         <= 12'd0;
      wdata        <= 8'd0;
      ch_ready_q   <= 1'b0;
      busy_q       <= CLEAR_ON_RESET;
      err_q        <= 1'b0;
    end else begin
      state        <= state_n;
      rem          <= rem_n;
      ptr          <= ptr_n;
      col          <= col_n;
      row          <= row_n;
      wbyte        <= wbyte_n;
      wrap_pending <= wrap_n;
      hsel         <= hsel_n;
      addr         <= addr_n;
      wdata        <= wdata_n;
      ch_ready_q   <= ch_ready_n;
      busy_q       <= busy_n;
      err_q        <= err_q | Hresponse;
    end
  end

  assign Hselect    = hsel;
  assign Hwrite     = hsel;
  assign ready      = hsel;
  assign Hsize      = 1'b0;
  assign Haddress   = addr;
  assign Hwritedata = {24'd0, wdata};
  assign ch_ready   = ch_ready_q;
  assign cursor_x   = col;
  assign cursor_y   = row;
  assign busy       = busy_q;
  assign err        = err_q;

endmodule

// File: tb/tb_vga_console.sv
// Scoreboard bench for vga_console: directed byte sequences push expected bus writes,
// a negedge monitor pops and checks every strobe.
`timescale 1ns/1ps
module tb_vga_console;

  logic        Hclock = 1'b0;
  logic        Hreset = 1'b0;
  logic [7:0]  ch_data = 8'd0;
  logic        ch_valid = 1'b0;
  logic        ch_ready;
  logic        Hselect, Hwrite, Hsize, ready;
  logic [11:0] Haddress;
  logic [31:0] Hwritedata;
  logic        Hready = 1'b1;
  logic        Hresponse = 1'b0;
  logic [6:0]  cursor_x;
  logic [4:0]  cursor_y;
  logic        busy, err;

  int          compared = 0;
  int          mismatched = 0;
  int          nwrites = 0;
  int          base;
  logic [43:0] sb[$];
  logic [43:0] mon_exp;
  logic        hready_prev = 1'b1;

  always #5 Hclock = ~Hclock;

  vga_console dut (
    .Hclock(Hclock), .Hreset(Hreset), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .Hselect(Hselect), .Hwrite(Hwrite), .Hsize(Hsize),
    .ready(ready), .Haddress(Haddress), .Hwritedata(Hwritedata), .Hready(Hready),
    .Hresponse(Hresponse), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .busy(busy), .err(err)
  );

  always @(posedge Hclock) hready_prev <= Hready;

  // Monitor: every strobe must be qualified and match the head of the scoreboard.
  always @(negedge Hclock) begin
    if (Hreset && Hselect) begin
      nwrites++;
      compared++;
      if (!hready_prev || !Hwrite || !ready || Hsize) begin
        mismatched++;
        $display("FAIL strobe_qual: prev_hready=%0b hwrite=%0b ready=%0b hsize=%0b required 1/1/1/0",
                 hready_prev, Hwrite, ready, Hsize);
      end
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_write: addr=%0d data=%0h, none required", Haddress, Hwritedata);
      end else begin
        mon_exp = sb.pop_front();
        if ({Haddress, Hwritedata} !== mon_exp) begin
          mismatched++;
          $display("FAIL write: addr=%0d data=%0h required addr=%0d data=%0h",
                   Haddress, Hwritedata, mon_exp[43:32], mon_exp[31:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push(input int a, input logic [7:0] d);
    sb.push_back({12'(a), 24'd0, d});
  endtask

  task automatic push_range(input int a, input int n);
    for (int i = 0; i < n; i++) push(a + i, 8'h20);
  endtask

  task automatic tick();
    @(posedge Hclock);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    while (ch_ready !== 1'b1 && t < 5000) begin
      tick();
      t++;
    end
    if (t >= 5000) begin
      compared++;
      mismatched++;
      $display("FAIL send_timeout: ch_ready=%0b required 1", ch_ready);
    end else begin
      ch_data  = b;
      ch_valid = 1'b1;
      tick();
      ch_valid = 1'b0;
    end
  endtask

  task automatic wait_idle(input int limit);
    int t;
    t = 0;
    while (!(ch_ready === 1'b1 && busy === 1'b0) && t < limit) begin
      tick();
      t++;
    end
    if (t >= limit) begin
      compared++;
      mismatched++;
      $display("FAIL idle_timeout: busy=%0b ch_ready=%0b required 0/1", busy, ch_ready);
    end
  endtask

  task automatic chk_cursor(input string name, input int x, input int y);
    chk({name, "_x"}, 32'(cursor_x), 32'(x));
    chk({name, "_y"}, 32'(cursor_y), 32'(y));
  endtask

  initial begin
    logic [7:0] c;
    repeat (3) tick();
    chk("rst_hselect", 32'(Hselect), 32'd0);
    chk("rst_addr", 32'(Haddress), 32'd0);
    chk("rst_wdata", Hwritedata, 32'd0);
    chk("rst_ch_ready", 32'(ch_ready), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk_cursor("rst_cursor", 0, 0);

    // Power-up clear of the whole screen
    push_range(0, 2400);
    Hreset = 1'b1;
    wait_idle(3000);
    chk("clr_all_left", 32'(sb.size()), 32'd0);
    chk("clr_all_count", 32'(nwrites), 32'd2400);
    chk("clr_all_ready", 32'(ch_ready), 32'd1);
    chk_cursor("clr_all_cursor", 0, 0);

    // 'A' at (0,0) with latency, ignored byte, CR
    push(0, 8'h41);
    send(8'h41);
    chk("a_strobe_n1", 32'(Hselect), 32'd1);
    chk("a_ready_n1", 32'(ch_ready), 32'd0);
    tick();
    chk("a_ready_n2", 32'(ch_ready), 32'd1);
    chk_cursor("a_cursor", 1, 0);
    send(8'h01);
    tick();
    chk_cursor("ignored_cursor", 1, 0);
    send(8'h0D);
    chk_cursor("cr_cursor", 0, 0);
    tick();
    chk("cr_busy", 32'(busy), 32'd0);

    // LF to row 1 with latency check, then LFs down to row 29
    push_range(80, 80);
    send(8'h0A);
    repeat (79) tick();
    chk("lf_ready_n80", 32'(ch_ready), 32'd0);
    chk("lf_strobe_n80", 32'(Hselect), 32'd1);
    chk("lf_addr_n80", 32'(Haddress), 32'd159);
    tick();
    chk("lf_ready_n81", 32'(ch_ready), 32'd1);
    chk("lf_strobe_n81", 32'(Hselect), 32'd0);
    for (int r = 2; r < 30; r++) begin
      push_range(r * 80, 80);
      send(8'h0A);
      wait_idle(500);
    end
    chk_cursor("row29_cursor", 0, 29);

    // Fill row 29 -> wrap to row 0, which gets blanked
    for (int i = 0; i < 80; i++) begin
      c = 8'(8'h30 + (i % 10));
      push(2320 + i, c);
      if (i == 79) push_range(0, 80);
      send(c);
    end
    wait_idle(500);
    chk("wrap_left", 32'(sb.size()), 32'd0);
    chk_cursor("wrap_cursor", 0, 0);

    // Backspace at row 2 col 5, then backspace at col 0
    push_range(80, 80);
    send(8'h0A);
    push_range(160, 80);
    send(8'h0A);
    for (int i = 0; i < 5; i++) begin
      c = 8'(8'h61 + i);
      push(160 + i, c);
      send(c);
    end
    push(165, 8'h78);
    send(8'h78);
    wait_idle(500);
    chk_cursor("x_cursor", 6, 2);
    push(165, 8'h20);
    send(8'h08);
    wait_idle(500);
    chk_cursor("bs_cursor", 5, 2);
    send(8'h0D);
    send(8'h08);
    tick();
    chk("bs0_busy", 32'(busy), 32'd0);
    chk_cursor("bs0_cursor", 0, 2);

    // Stall mid CLEAR_LINE with ch_valid held high
    wait_idle(500);
    base = nwrites;
    push_range(240, 80);
    send(8'h0A);
    repeat (20) tick();
    Hready   = 1'b0;
    ch_data  = 8'h5A;
    ch_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_strobe", 32'(Hselect), 32'd0);
      chk("stall_addr", 32'(Haddress), 32'd260);
      chk("stall_ch_ready", 32'(ch_ready), 32'd0);
    end
    Hready   = 1'b1;
    ch_valid = 1'b0;
    wait_idle(500);
    chk("stall_left", 32'(sb.size()), 32'd0);
    chk("stall_count", 32'(nwrites - base), 32'd80);
    chk_cursor("stall_cursor", 0, 3);

    // Sticky err, then reset in the middle of a form-feed clear
    chk("err_before", 32'(err), 32'd0);
    Hresponse = 1'b1;
    tick();
    Hresponse = 1'b0;
    chk("err_set", 32'(err), 32'd1);
    repeat (5) tick();
    chk("err_sticky", 32'(err), 32'd1);
    push_range(0, 2400);
    send(8'h0C);
    chk("ff_busy", 32'(busy), 32'd1);
    chk_cursor("ff_cursor_hold", 0, 3);
    repeat (100) tick();
    Hreset = 1'b0;
    #1;
    chk("rst2_hselect", 32'(Hselect), 32'd0);
    chk("rst2_addr", 32'(Haddress), 32'd0);
    chk("rst2_wdata", Hwritedata, 32'd0);
    chk("rst2_err", 32'(err), 32'd0);
    chk("rst2_ch_ready", 32'(ch_ready), 32'd0);
    chk_cursor("rst2_cursor", 0, 0);
    sb.delete();
    repeat (3) tick();
    push_range(0, 2400);
    Hreset = 1'b1;
    wait_idle(3000);
    chk("rst2_left", 32'(sb.size()), 32'd0);
    chk_cursor("rst2_final_cursor", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
